// File: rtl/div_tap_tick_gen.sv
// Ripple-divider tap consumer: synchronises D2..D16, edge-detects them into ticks,
// selects one tap glitch-free at the divider wrap, and counts selected ticks.
module div_tap_tick_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             D2,
    input  logic             D4,
    input  logic             D8,
    input  logic             D16,
    input  logic [1:0]       SEL,
    input  logic             SEL_LD,
    output logic             SEL_ACK,
    output logic [3:0]       TICK_ALL,
    output logic             TICK,
    output logic [CNT_W-1:0] TICK_CNT,
    input  logic             CNT_CLR,
    output logic             CNT_SAT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] s, s_d, rise;
    logic       fall16;

    logic [1:0] active_sel, sel_nxt;
    logic [1:0] pending, pend_nxt, req;
    logic       ack_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign fall16 = ~s[3] & s_d[3];

    // Synchronisers run in every state so enabling never sees a stale edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {D16, D8, D4, D2}};
            s_d    <= s;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            active_sel <= 2'b00;
            pending    <= 2'b00;
            SEL_ACK    <= 1'b0;
        end else begin
            state      <= state_nxt;
            active_sel <= sel_nxt;
            pending    <= pend_nxt;
            SEL_ACK    <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (EN) state_nxt = RUN;
            RUN: begin
                if (!EN)
                    state_nxt = IDLE;
                else if (SEL_LD && SEL != active_sel)
                    state_nxt = PEND;
            end
            PEND: begin
                if (!EN)
                    state_nxt = IDLE;
                else if (fall16)
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Switching only at fall16 keeps the old tap's period intact
    always_comb begin
        sel_nxt  = active_sel;
        pend_nxt = pending;
        ack_nxt  = 1'b0;
        req      = SEL_LD ? SEL : pending;
        unique case (state)
            IDLE: begin
                if (SEL_LD) begin
                    sel_nxt = SEL;
                    ack_nxt = 1'b1;
                end
            end
            RUN: begin
                if (SEL_LD) begin
                    if (!EN || SEL == active_sel) begin
                        sel_nxt = SEL;
                        ack_nxt = 1'b1;
                    end else begin
                        pend_nxt = SEL;
                    end
                end
            end
            PEND: begin
                pend_nxt = req;
                if (!EN || fall16) begin
                    sel_nxt = req;
                    ack_nxt = 1'b1;
                end
            end
            default: begin
                sel_nxt = active_sel;
            end
        endcase
    end

    always_comb begin
        cnt_nxt = TICK_CNT;
        if (CNT_CLR)
            cnt_nxt = '0;
        else if (TICK && !(&TICK_CNT))
            cnt_nxt = TICK_CNT + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            TICK_ALL <= '0;
            TICK     <= 1'b0;
            TICK_CNT <= '0;
            CNT_SAT  <= 1'b0;
        end else begin
            TICK_ALL <= rise & {4{EN}};
            TICK     <= rise[active_sel] & EN;
            TICK_CNT <= cnt_nxt;
            CNT_SAT  <= &cnt_nxt;
        end
    end

endmodule
